// File: rtl/spi_pkg.sv
// Shared types for the SPI leader: FSM state encoding and SPI mode constants.
package spi_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SETUP = 2'd1,
      XFER  = 2'd2,
      HOLD  = 2'd3
   } spi_state_e;

   // Mode encoding is {cpol, cpha}
   localparam logic [1:0] MODE0 = 2'b00;
   localparam logic [1:0] MODE1 = 2'b01;
   localparam logic [1:0] MODE2 = 2'b10;
   localparam logic [1:0] MODE3 = 2'b11;

endpackage

// File: rtl/spi_tick_gen.sv
// Half-period pacing: one-cycle tick every div+1 clocks, restarted on clr.
module spi_tick_gen (
   input  logic       clk,
   input  logic       rst,
   input  logic [2:0] div,
   input  logic       clr,
   output logic       tick
);

   logic [2:0] cnt;

   assign tick = (cnt == div);

   always_ff @(posedge clk or posedge rst) begin
      if (rst)               cnt <= '0;
      else if (clr || tick)  cnt <= '0;
      else                   cnt <= cnt + 3'd1;
   end

endmodule

// File: rtl/spi_leader_mc.sv
// Multi-chip-select SPI leader: one frame per accepted request, all four
// CPOL/CPHA modes, selectable bit order and half-period divider.
module spi_leader_mc
   import spi_pkg::*;
#(
   parameter int DATA_W = 16,
   parameter int NUM_CS = 4,
   parameter int CS_W   = (NUM_CS > 1) ? $clog2(NUM_CS) : 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cfg_cpol,
   input  logic              cfg_cpha,
   input  logic [2:0]        cfg_div,
   input  logic              cfg_lsb_first,
   input  logic              tx_valid,
   input  logic [DATA_W-1:0] tx_data,
   input  logic [CS_W-1:0]   tx_cs,
   output logic              tx_ready,
   output logic              rx_valid,
   output logic [DATA_W-1:0] rx_data,
   output logic              busy,
   output logic              sclk,
   output logic              mosi,
   input  logic              miso,
   output logic [NUM_CS-1:0] cs_n
);

   localparam int EC_W = $clog2(2*DATA_W+1);
   localparam logic [EC_W-1:0] LAST_EDGE = EC_W'(2*DATA_W);

   spi_state_e        state, state_nxt;
   logic [DATA_W-1:0] tx_sr, rx_sr, tx_ord;
   logic [CS_W-1:0]   cs_l;
   logic              cpha_l, lsb_l, ready_q, accept, tick;
   logic [2:0]        div_l;
   logic [EC_W-1:0]   ecnt, edge_nxt;

   function automatic logic [DATA_W-1:0] rev(input logic [DATA_W-1:0] d);
      logic [DATA_W-1:0] r;
      for (int i = 0; i < DATA_W; i++) r[i] = d[DATA_W-1-i];
      return r;
   endfunction

   assign accept   = tx_valid && ready_q;
   assign tx_ready = ready_q;
   assign busy     = (state != IDLE);
   assign edge_nxt = ecnt + 1'b1;
   // Both shift registers run LSB-out/LSB-in; MSB-first is a bit reversal at the ends.
   assign tx_ord   = cfg_lsb_first ? tx_data : rev(tx_data);

   spi_tick_gen u_tick (
      .clk  (clk),
      .rst  (rst),
      .div  (div_l),
      .clr  (state_nxt != state),
      .tick (tick)
   );

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (accept) state_nxt = SETUP;
         SETUP:   if (tick) state_nxt = XFER;
         XFER:    if (tick && edge_nxt == LAST_EDGE) state_nxt = HOLD;
         HOLD:    if (tick) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   for (genvar i = 0; i < NUM_CS; i++) begin : g_cs
      assign cs_n[i] = !(busy && cs_l == CS_W'(i));
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         ready_q  <= 1'b0;
         tx_sr    <= '0;
         rx_sr    <= '0;
         cs_l     <= '0;
         cpha_l   <= 1'b0;
         lsb_l    <= 1'b0;
         div_l    <= '0;
         ecnt     <= '0;
         sclk     <= 1'b0;
         mosi     <= 1'b0;
         rx_valid <= 1'b0;
         rx_data  <= '0;
      end else begin
         state    <= state_nxt;
         // Ready drops for the rx_valid cycle so back-to-back frames get a cs_n gap
         ready_q  <= (state_nxt == IDLE) && (state != HOLD);
         rx_valid <= 1'b0;
         if (accept) begin
            cs_l   <= tx_cs;
            cpha_l <= cfg_cpha;
            lsb_l  <= cfg_lsb_first;
            div_l  <= cfg_div;
            ecnt   <= '0;
            sclk   <= cfg_cpol;
            rx_sr  <= '0;
            if (cfg_cpha) begin
               mosi  <= 1'b0;
               tx_sr <= tx_ord;
            end else begin
               mosi  <= tx_ord[0];
               tx_sr <= tx_ord >> 1;
            end
         end
         if (state == XFER && tick) begin
            ecnt <= edge_nxt;
            sclk <= ~sclk;
            if (edge_nxt[0] == cpha_l) begin
               if (edge_nxt != LAST_EDGE) begin
                  mosi  <= tx_sr[0];
                  tx_sr <= tx_sr >> 1;
               end
            end else begin
               rx_sr <= {miso, rx_sr[DATA_W-1:1]};
            end
         end
         if (state == HOLD && tick) begin
            rx_valid <= 1'b1;
            rx_data  <= lsb_l ? rx_sr : rev(rx_sr);
            mosi     <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_spi_leader_mc.sv
// Self-checking bench for spi_leader_mc: directed table, random frames and
// hand-written back-to-back / mid-frame reset sequences.
module tb_spi_leader_mc;
   import spi_pkg::*;

   typedef struct {
      logic [7:0] data;
      logic [2:0] cs;
      logic       cpol;
      logic       cpha;
      logic [2:0] div;
      logic       lsb;
      logic       loop;
      logic [7:0] fw;
      logic [7:0] exp_rx;
      logic [3:0] exp_csn;
   } vec_t;

   logic       clk = 1'b0, rst = 1'b1;
   logic       cfg_cpol = 1'b0, cfg_cpha = 1'b0, cfg_lsb_first = 1'b0;
   logic [2:0] cfg_div = '0;
   logic       tx_valid = 1'b0;
   logic [7:0] tx_data = '0;
   logic [2:0] tx_cs = '0;
   logic       tx_ready, rx_valid, busy, sclk, mosi, miso;
   logic [7:0] rx_data;
   logic [3:0] cs_n;

   int   ncmp = 0, nfail = 0;
   int   fe_raw = 0, fe0 = 0, mq_base = 0, csn_err = 0, csn_base = 0, pulses = 0;
   logic mq[$];
   bit   in_frame = 1'b0;
   logic [7:0] fw = '0;
   logic flsb = 1'b0, fcpha = 1'b0, floop = 1'b1;
   logic [3:0] csn_exp = 4'hF;
   vec_t tbl[$];

   always #5 clk = ~clk;

   spi_leader_mc #(.DATA_W(8), .NUM_CS(4), .CS_W(3)) dut (
      .clk(clk), .rst(rst), .cfg_cpol(cfg_cpol), .cfg_cpha(cfg_cpha), .cfg_div(cfg_div),
      .cfg_lsb_first(cfg_lsb_first), .tx_valid(tx_valid), .tx_data(tx_data), .tx_cs(tx_cs),
      .tx_ready(tx_ready), .rx_valid(rx_valid), .rx_data(rx_data), .busy(busy),
      .sclk(sclk), .mosi(mosi), .miso(miso), .cs_n(cs_n)
   );

   // Follower: bit k of its word is on miso between the launch edges for bit k and k+1
   function automatic logic fol_bit(int e, logic [7:0] w, logic lsb, logic cpha);
      int k;
      k = cpha ? (e + 1) / 2 - 1 : e / 2;
      if (k < 0) k = 0;
      if (k > 7) k = 7;
      return lsb ? w[k] : w[7-k];
   endfunction

   assign miso = floop ? mosi : fol_bit(fe_raw - fe0, fw, flsb, fcpha);

   always @(sclk) begin
      if (in_frame) begin
         fe_raw = fe_raw + 1;
         if ((((fe_raw - fe0) % 2) == 1) != fcpha) mq.push_back(mosi);
      end
   end

   always @(negedge clk) begin
      if (in_frame && busy && cs_n !== csn_exp) csn_err = csn_err + 1;
      if (rx_valid) pulses = pulses + 1;
   end

   initial begin
      #5ms;
      $display("FAIL watchdog: time limit reached, got %0d compared", ncmp);
      $fatal(1, "watchdog");
   end

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      ncmp++;
      if (got !== exp) begin
         nfail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, got, exp);
      end
   endtask

   function automatic logic [3:0] m_csn(input logic [2:0] cs);
      return (cs < 3'd4) ? ~(4'b0001 << cs) : 4'hF;
   endfunction

   function automatic vec_t mk(input logic [7:0] d, input logic [2:0] cs, input logic [1:0] mode,
                               input logic [2:0] div, input logic lsb, input logic loop,
                               input logic [7:0] w, input logic [7:0] erx, input logic [3:0] ecsn);
      vec_t v;
      v.data = d; v.cs = cs; v.cpol = mode[1]; v.cpha = mode[0]; v.div = div;
      v.lsb = lsb; v.loop = loop; v.fw = w; v.exp_rx = erx; v.exp_csn = ecsn;
      return v;
   endfunction

   task automatic start_frame(input vec_t v);
      int n;
      @(negedge clk);
      cfg_cpol = v.cpol; cfg_cpha = v.cpha; cfg_div = v.div; cfg_lsb_first = v.lsb;
      tx_data = v.data; tx_cs = v.cs; tx_valid = 1'b1;
      fw = v.fw; flsb = v.lsb; fcpha = v.cpha; floop = v.loop; csn_exp = v.exp_csn;
      n = 0;
      while (!tx_ready && n < 100) begin @(negedge clk); n++; end
      chk("ready_before_accept", tx_ready, 1);
      @(posedge clk); #1;
      tx_valid = 1'b0;
      fe0 = fe_raw; mq_base = mq.size(); csn_base = csn_err; in_frame = 1'b1;
      chk("sclk_setup", sclk, v.cpol);
      chk("busy_setup", busy, 1);
      chk("csn_setup", cs_n, v.exp_csn);
      // Config changes after accept must not disturb the frame
      cfg_cpol = ~v.cpol; cfg_cpha = ~v.cpha; cfg_lsb_first = ~v.lsb;
      cfg_div = 3'($urandom_range(0, 7)); tx_data = ~v.data; tx_cs = 3'($urandom_range(0, 7));
   endtask

   task automatic finish_frame(input vec_t v);
      int n;
      logic [7:0] got;
      n = 0;
      while (!rx_valid && n < 400) begin @(posedge clk); #1; n++; end
      in_frame = 1'b0;
      chk("latency", n, 18 * (int'(v.div) + 1));
      chk("rx_data", rx_data, v.exp_rx);
      chk("sclk_edges", fe_raw - fe0, 16);
      chk("csn_frame", csn_err - csn_base, 0);
      chk("sclk_idle", sclk, v.cpol);
      chk("ready_in_pulse", tx_ready, 0);
      got = '0;
      for (int i = 0; i < 8; i++) begin
         if (mq_base + i < mq.size()) begin
            if (v.lsb) got[i] = mq[mq_base+i];
            else       got[7-i] = mq[mq_base+i];
         end
      end
      chk("mosi_samples", mq.size() - mq_base, 8);
      chk("mosi_bits", got, v.data);
      @(posedge clk); #1;
      chk("after_pulse_vld_rdy_mosi", {rx_valid, tx_ready, mosi}, 3'b010);
      chk("csn_idle", cs_n, 4'hF);
   endtask

   task automatic run_frame(input vec_t v);
      start_frame(v);
      finish_frame(v);
   endtask

   initial begin
      int n, gap, p0;
      vec_t v;

      // Directed rows
      tbl.push_back(mk(8'hA5, 3'd2, MODE0, 3'd0, 1'b0, 1'b1, 8'h00, 8'hA5, 4'b1011));
      tbl.push_back(mk(8'h3C, 3'd1, MODE3, 3'd3, 1'b1, 1'b0, 8'h96, 8'h96, 4'b1101));
      tbl.push_back(mk(8'h5A, 3'd5, MODE1, 3'd1, 1'b0, 1'b1, 8'h00, 8'h5A, 4'b1111));
      tbl.push_back(mk(8'h0F, 3'd0, MODE2, 3'd2, 1'b0, 1'b0, 8'hC3, 8'hC3, 4'b1110));
      tbl.push_back(mk(8'h81, 3'd3, MODE1, 3'd0, 1'b1, 1'b1, 8'h00, 8'h81, 4'b0111));
      tbl.push_back(mk(8'hE7, 3'd0, MODE2, 3'd7, 1'b1, 1'b0, 8'h2D, 8'h2D, 4'b1110));
      // Random rows, expectations from the reference rules
      for (int i = 0; i < 24; i++) begin
         v.data = 8'($urandom); v.cs = 3'($urandom_range(0, 5));
         v.cpol = 1'($urandom); v.cpha = 1'($urandom); v.div = 3'($urandom_range(0, 7));
         v.lsb = 1'($urandom); v.loop = 1'($urandom); v.fw = 8'($urandom);
         v.exp_rx = v.loop ? v.data : v.fw;
         v.exp_csn = m_csn(v.cs);
         tbl.push_back(v);
      end

      // Reset state
      repeat (3) @(negedge clk);
      chk("rst_ready", tx_ready, 0);
      chk("rst_csn", cs_n, 4'hF);
      chk("rst_sclk_mosi_vld_busy", {sclk, mosi, rx_valid, busy}, 4'b0000);
      chk("rst_rx_data", rx_data, 8'h00);
      rst = 1'b0;
      #1 chk("ready_before_first_edge", tx_ready, 0);
      @(posedge clk); #1;
      chk("ready_after_release", tx_ready, 1);

      foreach (tbl[i]) run_frame(tbl[i]);

      // Back-to-back with tx_valid held high
      @(negedge clk);
      cfg_cpol = 1'b0; cfg_cpha = 1'b0; cfg_div = 3'd1; cfg_lsb_first = 1'b0;
      tx_cs = 3'd1; tx_data = 8'h11; tx_valid = 1'b1; floop = 1'b1;
      p0 = pulses;
      n = 0;
      while (cs_n == 4'hF && n < 100) begin @(negedge clk); n++; end
      tx_data = 8'h22;
      n = 0;
      while (!rx_valid && n < 200) begin @(negedge clk); n++; end
      chk("b2b_first_rx", rx_data, 8'h11);
      gap = 0;
      while (cs_n == 4'hF && gap < 100) begin @(negedge clk); gap++; end
      tx_valid = 1'b0;
      chk("b2b_gap_ge1", gap >= 1, 1);
      chk("b2b_second_csn", cs_n, 4'b1101);
      n = 0;
      while (!rx_valid && n < 200) begin @(negedge clk); n++; end
      chk("b2b_second_rx", rx_data, 8'h22);
      repeat (3) @(negedge clk);
      chk("b2b_pulses", pulses - p0, 2);

      // Reset at sclk edge 7 of a frame
      v = mk(8'hC6, 3'd2, MODE0, 3'd0, 1'b0, 1'b1, 8'h00, 8'hC6, 4'b1011);
      start_frame(v);
      n = 0;
      while ((fe_raw - fe0) < 7 && n < 200) begin @(posedge clk); #2; n++; end
      in_frame = 1'b0;
      chk("rst_at_edge7", fe_raw - fe0, 7);
      p0 = pulses;
      rst = 1'b1;
      #1;
      chk("async_rst_csn", cs_n, 4'hF);
      chk("async_rst_sclk", sclk, 0);
      repeat (2) @(negedge clk);
      chk("mid_rst_ready_busy", {tx_ready, busy}, 2'b00);
      rst = 1'b0;
      repeat (40) @(negedge clk);
      chk("no_rx_after_abort", pulses - p0, 0);
      chk("rx_data_cleared", rx_data, 8'h00);
      run_frame(tbl[0]);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
      $finish;
   end

endmodule

// File: doc/spi_leader_mc.md
SPI_LEADER_MC -- requirements
Module: spi_leader_mc

Interface
REQ-001 Parameters: DATA_W, default 16, frame width in bits (4..32); NUM_CS, default 4, number of chip selects (1..16); CS_W, default $clog2(NUM_CS) (minimum 1), chip-select index width.
REQ-002 Ports: clk in 1 system clock; rst in 1 reset, asynchronous, active-high.
REQ-003 Config inputs: cfg_cpol in 1 clock polarity; cfg_cpha in 1 clock phase; cfg_div in 3 half-period select; cfg_lsb_first in 1 bit order.
REQ-004 TX inputs: tx_valid in 1 request; tx_data in DATA_W word to send; tx_cs in CS_W target chip select.
REQ-005 Handshake/status outputs: tx_ready out 1 accept; rx_valid out 1 received-word strobe; rx_data out DATA_W received word; busy out 1 transfer active.
REQ-006 SPI pins: sclk out 1 serial clock; mosi out 1 serial data out; miso in 1 serial data in; cs_n out NUM_CS active-low selects.

Function
REQ-007 Half-period H = cfg_div+1 clk cycles; a single-cycle tick every H cycles SHALL pace all SPI activity.
REQ-008 FSM states: IDLE, SETUP, XFER, HOLD; IDLE->SETUP on accept; SETUP->XFER after one H; XFER->HOLD after 2*DATA_W sclk edges; HOLD->IDLE after one H.
REQ-009 Accept occurs when tx_valid && tx_ready on a rising clk edge; tx_ready = 1 only in IDLE.
REQ-010 On accept, tx_data, tx_cs, cfg_cpol, cfg_cpha, cfg_div and cfg_lsb_first are latched; config changes after accept have no effect until the next accept.
REQ-011 cs_n[tx_cs] = 0 from SETUP entry until HOLD exit; all other bits = 1; tx_cs >= NUM_CS: transfer runs, all cs_n stay 1.
REQ-012 sclk = latched cpol in IDLE, SETUP and HOLD; it toggles once per tick in XFER, 2*DATA_W toggles in total.
REQ-013 cpha=0: first bit on mosi at SETUP entry; miso sampled on odd edges (1,3,..); mosi advances on even edges except the final one.
REQ-014 cpha=1: mosi advances on odd edges; miso sampled on even edges.
REQ-015 Bit order: MSB first when lsb_first=0, LSB first when lsb_first=1; rx_data assembled in the same order.
REQ-016 rx_valid is a one-cycle pulse in the HOLD->IDLE cycle; rx_data is updated in the same cycle and held until the next pulse; no backpressure, so an unread word is overwritten.
REQ-017 busy = 1 in SETUP, XFER and HOLD.
REQ-018 Latency: accept to rx_valid = (2*DATA_W+2)*H clk cycles; tx_ready returns high the cycle after rx_valid.
REQ-019 tx_valid held during busy is not lost; it is accepted on return to IDLE, giving back-to-back frames with cs_n deasserted for at least one clk cycle.
REQ-020 mosi = 0 in IDLE.

Reset
REQ-021 rst asserted: FSM = IDLE, sclk = 0, cs_n all 1, mosi = 0, tx_ready = 0 while rst high, then 1 from the first clk edge after release; rx_valid = 0, rx_data = 0, busy = 0, counters cleared.
REQ-022 rst mid-transfer aborts immediately: cs_n deasserts asynchronously, no rx_valid pulse, partial data discarded.

Structure
REQ-023 Package spi_pkg holds the FSM state enum and the CPOL/CPHA mode constants (MODE0..MODE3).
REQ-024 Sub-module spi_tick_gen (counter plus cfg_div compare, tick output, clear on state change); the shift/sample datapath stays in spi_leader_mc.

Verification
REQ-025 Mode 0, DATA_W=8, div=0, tx_data=0xA5, tx_cs=2, miso looped from mosi -> cs_n=4'b1011 during the frame, 16 sclk edges, rx_data=0xA5, rx_valid exactly 18 cycles after accept.
REQ-026 Mode 3, div=3, lsb_first=1, tx_data=0x3C, miso driven with 0x96 LSB-first -> sclk idles 1, H=4 cycles, mosi sequence 0,0,1,1,1,1,0,0, rx_data=0x96.
REQ-027 tx_valid held high with 0x11 then 0x22 -> two frames, cs_n high for at least 1 cycle between them, two rx_valid pulses, no word dropped.
REQ-028 tx_cs=5 with NUM_CS=4 -> cs_n stays 4'b1111, busy and rx_valid timing identical to a valid index.
REQ-029 rst pulsed at edge 7 of a 16-edge frame -> cs_n=all 1 and sclk=0 asynchronously, no rx_valid, next transfer completes correctly.
REQ-030 cfg_cpol toggled mid-frame -> sclk idle level and edges follow the latched value until frame end.
